ahb_wrr_slave_arbiter: RTL and testbench
========================================

Name: ahb_wrr_slave_arbiter

Overview:
- Weighted round-robin arbiter for one AHB slave port shared by MASTER_NUM masters.
- Picks a winner among requesting masters with remaining credit and holds the grant for the full burst, counting beats on hready.
- On the last beat it hands over to the next master back-to-back.
- Sits between the master request lines and the slave-side address/data mux; hmaster drives the mux select.

Parameters:
- MASTER_NUM, 4, number of masters sharing the slave (2..8).
- WEIGHT_BIT, 4, width of per-master weight/credit.
- INCR_MAX, 16, maximum beats granted to an undefined-length INCR burst before forced re-arbitration.

Ports:
- hclk  input  1  clock.
- hreset_n  input  1  asynchronous active-low reset.
- hreq  input  MASTER_NUM  per-master bus request.
- hburst  input  MASTER_NUM x hburst_type  per-master burst type, valid while hreq is high.
- hready  input  1  slave ready; a beat completes on a cycle with hready=1 while granted.
- hweight  input  MASTER_NUM x WEIGHT_BIT  static per-master weight; 0 is treated as 1.
- hgrant  output  MASTER_NUM  one-hot grant, registered.
- hmaster  output  $clog2(MASTER_NUM)  index of the granted master; 0 when idle.
- hsel  output  1  slave select, equal to |hgrant.
- hlast  output  1  pulse on the cycle the final beat of the owner's burst completes.

Behaviour:
- Reset (async, active-low):
  - hgrant=0, hmaster=0, hsel=0, hlast=0.
  - state=IDLE, beat count=0, all credits=0.
  - rr pointer=MASTER_NUM-1, so master 0 has first priority.
- States: IDLE, OWN.
- Eligibility: master i is eligible when hreq[i]=1 and credit[i]>0.
- Credit reload: if requests exist but none is eligible, all credits reload to max(hweight[i],1) in that cycle, and the pick uses the reloaded values (no lost cycle).
- Pick: the first eligible master scanning upward from pointer+1, wrapping at MASTER_NUM-1 to 0.
- IDLE:
  - If any hreq, pick a winner; next cycle hgrant=onehot(winner), state=OWN.
  - Beat count cleared; burst type latched from hburst[winner].
  - Grant latency is one cycle from hreq.
- OWN:
  - Beat count increments on each hready=1 cycle.
  - Burst length: SINGLE=1, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16.
  - Fixed-length burst: the last beat is the beat where count == length-1 and hready=1.
  - INCR: the last beat is either the first hready=1 cycle with hreq[owner]=0, or beat INCR_MAX-1.
- On the last beat:
  - hlast=1 for that cycle.
  - credit[owner] decrements, saturating at 0.
  - pointer=owner.
  - If any request (owner included), pick the next winner the same cycle; new hgrant takes effect the next cycle with no idle gap. Otherwise go to IDLE and hgrant=0.
- hready=0 stalls the count; the grant is held indefinitely.
- The owner deasserting hreq during a fixed-length burst is ignored: the grant is held until the count completes.
- Arbitration happens only in IDLE or on a last beat. New requests never preempt mid-burst.
- A single requester keeps winning: credits reload each time they run out.
- Weight change while in use takes effect at the next reload only.
- Reset asserted mid-burst: all outputs clear immediately and asynchronously; no hlast is produced.
- Count width is 5 bits to cover INCR_MAX up to 31. INCR_MAX > 31 is illegal (elaboration assertion).

Decomposition:
- AHB_package (existing) provides hburst_type.
- Add to AHB_package: function burst_len(hburst_type) returning 5-bit length (INCR returns 0, meaning undefined).
- Add to AHB_package: enum arb_state_t {IDLE, OWN}.
- Sub-module ahb_rr_picker: combinational; inputs eligible vector and pointer, outputs one-hot winner and valid flag. Instantiated twice: once on the eligible vector, once on the reloaded vector; the reload path selects between them.

Test Plan:
- Reset, then hreq=4'b0001 with hburst=SINGLE and hready=1 → hgrant=0001 one cycle later; hlast=1 the same cycle; hgrant=0 the following cycle.
- hreq=1111, all hweight=1, all SINGLE → grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles; credit reload happens at the 5th pick.
- hweight={1,1,1,3} (m3=3), all requesting SINGLE continuously → per 6 grants, m3 gets 3 and m0–m2 get 1 each.
- m1 INCR8 with hready low on beats 2 and 5, m2 requesting throughout → hgrant stays 0010 for 10 cycles; hlast on the 10th; 0100 granted on the next cycle.
- m0 INCR holding hreq with INCR_MAX=16, m1 requesting → m0 is forced off after 16 ready beats with hlast; m1 granted next.
- Assert hreset_n=0 at beat 3 of a WRAP16 burst → hgrant, hsel and hlast go to 0 immediately. After release, the rr pointer restarts at master 0.

Source files
------------

// File: rtl/ahb_wrr_slave_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_wrr_slave_arbiter_pkg
// Description : Shared types for the weighted round-robin AHB slave arbiter:
//               AHB burst encoding, burst length decode and arbiter states.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_wrr_slave_arbiter_pkg;

    // AHB HBURST encoding
    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_type;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Number of beats in a fixed-length burst; 0 marks an undefined-length INCR.
    function automatic logic [4:0] burst_len(input hburst_type b);
        case (b)
            SINGLE:         return 5'd1;
            WRAP4, INCR4:   return 5'd4;
            WRAP8, INCR8:   return 5'd8;
            WRAP16, INCR16: return 5'd16;
            default:        return 5'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_wrr_slave_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_wrr_slave_arbiter_if
// Description : Request/grant bundle between the masters and the arbiter.
//               hreq/hburst/hweight/hready flow towards the arbiter,
//               hgrant/hmaster/hsel/hlast flow back.
//               modport slave  : arbiter side
//               modport master : request side (masters / slave ready source)
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb_wrr_slave_arbiter_if
    import ahb_wrr_slave_arbiter_pkg::*;
#(
    parameter int MASTER_NUM = 4,
    parameter int WEIGHT_BIT = 4
) ();

    logic [MASTER_NUM-1:0]         hreq;
    hburst_type                    hburst  [MASTER_NUM];
    logic                          hready;
    logic [WEIGHT_BIT-1:0]         hweight [MASTER_NUM];
    logic [MASTER_NUM-1:0]         hgrant;
    logic [$clog2(MASTER_NUM)-1:0] hmaster;
    logic                          hsel;
    logic                          hlast;

    modport slave (
        input  hreq, hburst, hready, hweight,
        output hgrant, hmaster, hsel, hlast
    );

    modport master (
        output hreq, hburst, hready, hweight,
        input  hgrant, hmaster, hsel, hlast
    );

endinterface
`default_nettype wire

// File: rtl/ahb_wrr_slave_arbiter_picker.sv
`default_nettype none
// ============================================================================
// Module      : ahb_rr_picker
// Description : Combinational round-robin picker. Returns the first set bit of
//               req scanning upward from ptr+1 and wrapping to 0.
//   req   : candidate vector
//   ptr   : index of the last winner (lowest priority)
//   grant : one-hot winner
//   valid : a winner exists
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_rr_picker #(
    parameter int MASTER_NUM = 4,
    parameter int PTR_W      = 2
) (
    input  logic [MASTER_NUM-1:0] req,
    input  logic [PTR_W-1:0]      ptr,
    output logic [MASTER_NUM-1:0] grant,
    output logic                  valid
);

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] p, input int k);
        return PTR_W'((int'(p) + k) % MASTER_NUM);
    endfunction

    always_comb begin
        grant = '0;
        valid = 1'b0;
        // k = MASTER_NUM revisits ptr itself as the lowest-priority candidate
        for (int k = 1; k <= MASTER_NUM; k++) begin
            if (!valid && req[wrap_idx(ptr, k)]) begin
                grant[wrap_idx(ptr, k)] = 1'b1;
                valid                   = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_wrr_slave_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ahb_wrr_slave_arbiter
// Description : Weighted round-robin arbiter for one AHB slave port. Grants a
//               master for a whole burst, counts beats on hready and hands
//               over back-to-back on the final beat.
//   hclk     : clock
//   hreset_n : asynchronous active-low reset
//   bus      : request/grant bundle (hreq, hburst, hready, hweight in;
//              hgrant, hmaster, hsel, hlast out)
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_wrr_slave_arbiter
    import ahb_wrr_slave_arbiter_pkg::*;
#(
    parameter int MASTER_NUM = 4,
    parameter int WEIGHT_BIT = 4,
    parameter int INCR_MAX   = 16
) (
    input  logic                   hclk,
    input  logic                   hreset_n,
    ahb_wrr_slave_arbiter_if.slave bus
);

    localparam int         C_PTR_W     = $clog2(MASTER_NUM);
    localparam logic [4:0] C_INCR_LAST = 5'(INCR_MAX - 1);

    generate
        if (INCR_MAX < 1 || INCR_MAX > 31) begin : g_bad_incr_max
            $error("INCR_MAX must be within 1..31");
        end
        if (MASTER_NUM < 2 || MASTER_NUM > 8) begin : g_bad_master_num
            $error("MASTER_NUM must be within 2..8");
        end
    endgenerate

    arb_state_t            r_state;
    logic [MASTER_NUM-1:0] r_grant;
    logic [C_PTR_W-1:0]    r_owner;
    logic [C_PTR_W-1:0]    r_ptr;
    logic [4:0]            r_count;
    hburst_type            r_burst;
    logic [WEIGHT_BIT-1:0] r_credit [MASTER_NUM];

    logic [4:0]            w_len;
    logic                  w_last;
    logic                  w_arb_en;
    logic [C_PTR_W-1:0]    w_pick_ptr;
    logic [WEIGHT_BIT-1:0] w_cred_eff   [MASTER_NUM];
    logic [WEIGHT_BIT-1:0] w_reload_val [MASTER_NUM];
    logic [MASTER_NUM-1:0] w_elig;
    logic [MASTER_NUM-1:0] w_oh_elig;
    logic [MASTER_NUM-1:0] w_oh_reload;
    logic [MASTER_NUM-1:0] w_win_oh;
    logic                  w_v_elig;
    logic                  w_v_reload;
    logic                  w_win_valid;
    logic                  w_any_req;
    logic                  w_reload;
    logic [C_PTR_W-1:0]    w_win_idx;

    assign w_len = burst_len(r_burst);

    // Final beat: fixed bursts end on count == len-1; INCR ends when the owner
    // drops its request or the beat cap is reached.
    always_comb begin
        w_last = 1'b0;
        if (r_state == OWN && bus.hready) begin
            if (w_len != 5'd0) begin
                w_last = (r_count == w_len - 5'd1);
            end else begin
                w_last = !bus.hreq[r_owner] || (r_count == C_INCR_LAST);
            end
        end
    end

    assign w_arb_en   = (r_state == IDLE) || w_last;
    // On a final beat the outgoing owner becomes the new lowest priority now.
    assign w_pick_ptr = w_last ? r_owner : r_ptr;

    // Eligibility sees the owner's credit already charged for the finishing
    // burst, so a master that spends its last credit cannot win immediately.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            w_reload_val[i] = (bus.hweight[i] == '0) ? WEIGHT_BIT'(1) : bus.hweight[i];
            w_cred_eff[i]   = r_credit[i];
            if (w_last && r_owner == C_PTR_W'(i) && r_credit[i] != '0) begin
                w_cred_eff[i] = r_credit[i] - WEIGHT_BIT'(1);
            end
            w_elig[i] = bus.hreq[i] && (w_cred_eff[i] != '0);
        end
    end

    assign w_any_req = |bus.hreq;
    // After a reload every requester has credit >= 1, so the reloaded
    // eligible vector is simply hreq.
    assign w_reload  = w_any_req && !(|w_elig);

    ahb_rr_picker #(
        .MASTER_NUM (MASTER_NUM),
        .PTR_W      (C_PTR_W)
    ) u_pick_elig (
        .req   (w_elig),
        .ptr   (w_pick_ptr),
        .grant (w_oh_elig),
        .valid (w_v_elig)
    );

    ahb_rr_picker #(
        .MASTER_NUM (MASTER_NUM),
        .PTR_W      (C_PTR_W)
    ) u_pick_reload (
        .req   (bus.hreq),
        .ptr   (w_pick_ptr),
        .grant (w_oh_reload),
        .valid (w_v_reload)
    );

    assign w_win_oh    = w_reload ? w_oh_reload : w_oh_elig;
    assign w_win_valid = w_reload ? w_v_reload  : w_v_elig;

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (w_win_oh[i]) begin
                w_win_idx = C_PTR_W'(i);
            end
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= C_PTR_W'(MASTER_NUM - 1);
            r_count <= '0;
            r_burst <= SINGLE;
            for (int i = 0; i < MASTER_NUM; i++) begin
                r_credit[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MASTER_NUM; i++) begin
                r_credit[i] <= (w_arb_en && w_reload) ? w_reload_val[i] : w_cred_eff[i];
            end
            if (w_last) begin
                r_ptr <= r_owner;
            end
            if (w_arb_en) begin
                if (w_win_valid) begin
                    r_state <= OWN;
                    r_grant <= w_win_oh;
                    r_owner <= w_win_idx;
                    r_count <= '0;
                    r_burst <= bus.hburst[w_win_idx];
                end else begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_owner <= '0;
                    r_count <= '0;
                end
            end else if (bus.hready) begin
                r_count <= r_count + 5'd1;
            end
        end
    end

    assign bus.hgrant  = r_grant;
    assign bus.hmaster = r_owner;
    assign bus.hsel    = |r_grant;
    assign bus.hlast   = w_last;

endmodule
`default_nettype wire

// File: tb/tb_ahb_wrr_slave_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_wrr_slave_arbiter
// Description : Self-checking bench for ahb_wrr_slave_arbiter: directed
//               scenarios with constant expectations plus a randomized run
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_wrr_slave_arbiter;
    import ahb_wrr_slave_arbiter_pkg::*;

    localparam int M  = 4;
    localparam int WB = 4;
    localparam int IM = 16;

    logic hclk = 1'b0;
    logic hreset_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    ahb_wrr_slave_arbiter_if #(.MASTER_NUM(M), .WEIGHT_BIT(WB)) bus ();

    ahb_wrr_slave_arbiter #(
        .MASTER_NUM (M),
        .WEIGHT_BIT (WB),
        .INCR_MAX   (IM)
    ) dut (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .bus      (bus)
    );

    always #5 hclk = ~hclk;

    // ---------------- reference model (transaction level) ----------------
    int m_cred [M];
    int m_ptr;
    bit m_busy;
    int m_owner;
    int m_beats;
    int m_len;

    function automatic int len_of(input hburst_type b);
        case (b)
            SINGLE:         return 1;
            INCR:           return 0;
            WRAP4, INCR4:   return 4;
            WRAP8, INCR8:   return 8;
            default:        return 16;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < M; i++) m_cred[i] = 0;
        m_ptr = M - 1; m_busy = 0; m_owner = 0; m_beats = 0; m_len = 1;
    endfunction

    function automatic bit model_last();
        if (!m_busy || !bus.hready) return 0;
        if (m_len != 0) return (m_beats + 1 == m_len);
        return (!bus.hreq[m_owner]) || (m_beats + 1 == IM);
    endfunction

    function automatic void model_advance();
        bit last = model_last();
        bit any_elig = 0;
        bit found = 0;
        if (m_busy && bus.hready && !last) m_beats++;
        if (last) begin
            if (m_cred[m_owner] > 0) m_cred[m_owner]--;
            m_ptr = m_owner;
        end
        if (!m_busy || last) begin
            if (bus.hreq != '0) begin
                for (int i = 0; i < M; i++) if (bus.hreq[i] && m_cred[i] > 0) any_elig = 1;
                if (!any_elig)
                    for (int i = 0; i < M; i++) m_cred[i] = (bus.hweight[i] == 0) ? 1 : int'(bus.hweight[i]);
                for (int k = 1; k <= M; k++) begin
                    int j = (m_ptr + k) % M;
                    if (!found && bus.hreq[j] && m_cred[j] > 0) begin
                        found = 1; m_owner = j;
                    end
                end
                m_busy = 1; m_beats = 0; m_len = len_of(bus.hburst[m_owner]);
            end else begin
                m_busy = 0; m_owner = 0;
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge hclk); #1;
    endtask

    task automatic set_all(input logic [M-1:0] req, input hburst_type b, input int w);
        bus.hreq = req;
        for (int i = 0; i < M; i++) begin
            bus.hburst[i]  = b;
            bus.hweight[i] = WB'(w);
        end
    endtask

    task automatic do_reset();
        hreset_n = 1'b0;
        set_all('0, SINGLE, 1);
        bus.hready = 1'b1;
        tick(); tick();
        hreset_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        hreset_n = 1'b0;
        set_all('0, SINGLE, 1);
        bus.hready = 1'b1;
        tick();
        @(negedge hclk);
        n_cmp++;
        if ({bus.hgrant, bus.hmaster, bus.hsel, bus.hlast} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got grant=%b master=%0d sel=%b last=%b, want all 0",
                     bus.hgrant, bus.hmaster, bus.hsel, bus.hlast);
        end
        tick();
        hreset_n = 1'b1;
        @(negedge hclk);
        n_cmp++;
        if ({bus.hgrant, bus.hmaster, bus.hsel, bus.hlast} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got grant=%b sel=%b last=%b, want all 0",
                     bus.hgrant, bus.hsel, bus.hlast);
        end
        tick();
    endtask

    task automatic test_single();
        do_reset();
        set_all(4'b0001, SINGLE, 1);
        @(negedge hclk);
        n_cmp++;
        if (bus.hgrant !== 4'b0000) begin
            n_fail++; $display("FAIL single_latency: grant=%b want 0000", bus.hgrant);
        end
        tick();
        bus.hreq = 4'b0000;
        @(negedge hclk);
        n_cmp++;
        if (bus.hgrant !== 4'b0001 || bus.hlast !== 1'b1 || bus.hsel !== 1'b1 || bus.hmaster !== 2'd0) begin
            n_fail++;
            $display("FAIL single_grant: grant=%b last=%b sel=%b master=%0d want 0001/1/1/0",
                     bus.hgrant, bus.hlast, bus.hsel, bus.hmaster);
        end
        tick();
        @(negedge hclk);
        n_cmp++;
        if (bus.hgrant !== 4'b0000 || bus.hsel !== 1'b0 || bus.hlast !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: grant=%b sel=%b last=%b want 0000/0/0",
                     bus.hgrant, bus.hsel, bus.hlast);
        end
    endtask

    task automatic test_round_robin();
        logic [M-1:0] exp_oh [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                     4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        set_all(4'b1111, SINGLE, 1);
        tick();
        for (int k = 0; k < 8; k++) begin
            @(negedge hclk);
            n_cmp++;
            if (bus.hgrant !== exp_oh[k] || bus.hlast !== 1'b1 || bus.hmaster !== 2'(k % 4)) begin
                n_fail++;
                $display("FAIL rr_seq[%0d]: grant=%b last=%b master=%0d want %b/1/%0d",
                         k, bus.hgrant, bus.hlast, bus.hmaster, exp_oh[k], k % 4);
            end
            tick();
        end
    endtask

    task automatic test_weighted();
        int exp_idx [12] = '{0, 1, 2, 3, 3, 3, 0, 1, 2, 3, 3, 3};
        int m3_wins = 0;
        do_reset();
        set_all(4'b1111, SINGLE, 1);
        bus.hweight[3] = 4'd3;
        tick();
        for (int k = 0; k < 12; k++) begin
            @(negedge hclk);
            if (k < 6 && bus.hgrant === 4'b1000) m3_wins++;
            n_cmp++;
            if (bus.hgrant !== (4'b0001 << exp_idx[k])) begin
                n_fail++;
                $display("FAIL wrr_seq[%0d]: grant=%b want %b", k, bus.hgrant, 4'b0001 << exp_idx[k]);
            end
            tick();
        end
        n_cmp++;
        if (m3_wins != 3) begin
            n_fail++; $display("FAIL wrr_share: m3 wins=%0d want 3", m3_wins);
        end
    endtask

    task automatic test_incr8_stall();
        do_reset();
        set_all(4'b0110, SINGLE, 1);
        bus.hburst[1] = INCR8;
        tick();
        for (int c = 1; c <= 10; c++) begin
            bus.hready = (c == 2 || c == 5) ? 1'b0 : 1'b1;
            @(negedge hclk);
            n_cmp++;
            if (bus.hgrant !== 4'b0010 || bus.hlast !== (c == 10)) begin
                n_fail++;
                $display("FAIL incr8_cycle[%0d]: grant=%b last=%b want 0010/%b",
                         c, bus.hgrant, bus.hlast, (c == 10));
            end
            tick();
        end
        bus.hready = 1'b1;
        @(negedge hclk);
        n_cmp++;
        if (bus.hgrant !== 4'b0100) begin
            n_fail++; $display("FAIL incr8_handover: grant=%b want 0100", bus.hgrant);
        end
    endtask

    task automatic test_incr_max();
        do_reset();
        set_all(4'b0011, SINGLE, 1);
        bus.hburst[0] = INCR;
        tick();
        for (int c = 1; c <= IM; c++) begin
            @(negedge hclk);
            n_cmp++;
            if (bus.hgrant !== 4'b0001 || bus.hlast !== (c == IM)) begin
                n_fail++;
                $display("FAIL incr_cap[%0d]: grant=%b last=%b want 0001/%b",
                         c, bus.hgrant, bus.hlast, (c == IM));
            end
            tick();
        end
        @(negedge hclk);
        n_cmp++;
        if (bus.hgrant !== 4'b0010) begin
            n_fail++; $display("FAIL incr_cap_handover: grant=%b want 0010", bus.hgrant);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_all(4'b0100, SINGLE, 1);
        bus.hburst[1] = WRAP16;
        tick();                       // m2 granted (SINGLE)
        bus.hreq = 4'b0010;           // m1 picked on m2's last beat
        tick();                       // m1 beat 1
        tick();                       // m1 beat 2
        tick();                       // m1 beat 3
        n_cmp++;
        if (bus.hgrant !== 4'b0010) begin
            n_fail++; $display("FAIL wrap16_owner: grant=%b want 0010", bus.hgrant);
        end
        #2 hreset_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.hgrant !== 4'b0000 || bus.hsel !== 1'b0 || bus.hlast !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: grant=%b sel=%b last=%b want 0000/0/0",
                     bus.hgrant, bus.hsel, bus.hlast);
        end
        tick();
        set_all(4'b1111, SINGLE, 1);
        hreset_n = 1'b1;
        tick();
        @(negedge hclk);
        n_cmp++;
        if (bus.hgrant !== 4'b0001) begin
            n_fail++; $display("FAIL ptr_restart: grant=%b want 0001", bus.hgrant);
        end
    endtask

    task automatic test_random();
        logic [M-1:0] exp_grant;
        logic [1:0]   exp_master;
        bit           exp_last;
        do_reset();
        model_reset();
        for (int i = 0; i < M; i++) begin
            bus.hweight[i] = WB'($urandom_range(0, 4));
            bus.hburst[i]  = hburst_type'($urandom_range(0, 7));
        end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < M; i++) begin
                if ($urandom_range(0, 3) == 0) bus.hreq[i] = ~bus.hreq[i];
                if ($urandom_range(0, 2) == 0) bus.hburst[i] = hburst_type'($urandom_range(0, 7));
                if ($urandom_range(0, 200) == 0) bus.hweight[i] = WB'($urandom_range(0, 5));
            end
            bus.hready = ($urandom_range(0, 3) != 0);
            @(negedge hclk);
            exp_last   = model_last();
            exp_grant  = m_busy ? (4'b0001 << m_owner) : 4'b0000;
            exp_master = m_busy ? 2'(m_owner) : 2'd0;
            n_cmp++;
            if (bus.hgrant !== exp_grant || bus.hmaster !== exp_master ||
                bus.hsel !== (exp_grant != 0) || bus.hlast !== exp_last) begin
                n_fail++;
                $display("FAIL random[%0d]: grant=%b master=%0d sel=%b last=%b want %b/%0d/%b/%b",
                         c, bus.hgrant, bus.hmaster, bus.hsel, bus.hlast,
                         exp_grant, exp_master, (exp_grant != 0), exp_last);
            end
            model_advance();
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        hreset_n = 1'b0;
        bus.hready = 1'b1;
        set_all('0, SINGLE, 1);
        test_reset();
        test_single();
        test_round_robin();
        test_weighted();
        test_incr8_stall();
        test_incr_max();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
